// File: rtl/lnrv_ifu_iqueue_pkg.sv
// rtl/lnrv_ifu_iqueue_pkg.sv - shared constants, entry layout and pre-decode helper for the IFU instruction queue
package lnrv_ifu_iqueue_pkg;

  localparam int LNRV_IQ_DEPTH = 4;
  localparam int LNRV_XLEN     = 32;

  typedef struct packed {
    logic [LNRV_XLEN-1:0] pc;
    logic [LNRV_XLEN-1:0] ir;
    logic                 misalgn;
    logic                 buserr;
  } iq_entry_t;

  localparam int IQ_ENTRY_W = $bits(iq_entry_t);

  // Without compressed support, any encoding whose low bits are not 2'b11 is illegal,
  // but a fetch exception takes precedence over the length check.
  function automatic logic ir_len_illegal(input iq_entry_t e);
    return ~e.misalgn & ~e.buserr & (e.ir[1:0] != 2'b11);
  endfunction

endpackage

// File: rtl/lnrv_gnrl_sync_fifo.sv
// rtl/lnrv_gnrl_sync_fifo.sv - generic synchronous FIFO with wrap-bit pointers and synchronous clear
module lnrv_gnrl_sync_fifo #(
  parameter int DW    = 66,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic          do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) & (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q[AW-1:0]] = wdata;
        wr_ptr_d                = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/lnrv_ifu_iqueue.sv
// rtl/lnrv_ifu_iqueue.sv - instruction queue between IFU and EXU with flush, count and illegal-length pre-decode
module lnrv_ifu_iqueue
  import lnrv_ifu_iqueue_pkg::*;
#(
  parameter int DEPTH = LNRV_IQ_DEPTH,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pipe_flush_req,
  input  logic             ifu_ir_vld,
  output logic             ifu_ir_rdy,
  input  logic [31:0]      ifu_pc,
  input  logic [31:0]      ifu_ir,
  input  logic             ifu_misalgn,
  input  logic             ifu_buserr,
  output logic             iq_ir_vld,
  input  logic             iq_ir_rdy,
  output logic [31:0]      iq_pc,
  output logic [31:0]      iq_ir,
  output logic             iq_misalgn,
  output logic             iq_buserr,
  output logic             iq_ilegl,
  output logic [CNT_W-1:0] iq_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  iq_entry_t        wr_entry;
  iq_entry_t        head;
  logic             fifo_full, fifo_empty;
  logic             push, pop;
  logic [CNT_W-1:0] count_q, count_d;

  // Ready depends only on registered state and flush, never on iq_ir_rdy, so a
  // full queue stays not-ready even in a cycle where the EXU pops.
  assign ifu_ir_rdy = ~fifo_full | pipe_flush_req;
  assign iq_ir_vld  = ~fifo_empty & ~pipe_flush_req;
  assign push       = ifu_ir_vld & ifu_ir_rdy & ~pipe_flush_req;
  assign pop        = iq_ir_vld & iq_ir_rdy;

  assign wr_entry.pc      = ifu_pc;
  assign wr_entry.ir      = ifu_ir;
  assign wr_entry.misalgn = ifu_misalgn;
  assign wr_entry.buserr  = ifu_buserr;

  lnrv_gnrl_sync_fifo #(
    .DW    (IQ_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (pipe_flush_req),
    .push    (push),
    .pop     (pop),
    .wdata   (wr_entry),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign iq_pc      = head.pc;
  assign iq_ir      = head.ir;
  assign iq_misalgn = head.misalgn;
  assign iq_buserr  = head.buserr;
  assign iq_ilegl   = iq_ir_vld & ir_len_illegal(head);
  assign iq_count   = count_q;

  always_comb begin
    count_d = count_q;
    if (pipe_flush_req) begin
      count_d = '0;
    end else if (push & ~pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop & ~push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Handshake protocol checks on both sides of the queue.
  a_ifu_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (ifu_ir_vld & ~ifu_ir_rdy) |=> (~ifu_ir_vld | $stable({ifu_pc, ifu_ir, ifu_misalgn, ifu_buserr})));

  a_iq_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (iq_ir_vld & ~iq_ir_rdy) |=> (~iq_ir_vld | $stable({iq_pc, iq_ir, iq_misalgn, iq_buserr, iq_ilegl})));

endmodule

// File: tb/tb_lnrv_ifu_iqueue.sv
// tb/tb_lnrv_ifu_iqueue.sv - directed vector table, streaming sequence and random model check for lnrv_ifu_iqueue
module tb_lnrv_ifu_iqueue;
  import lnrv_ifu_iqueue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             pipe_flush_req;
  logic             ifu_ir_vld;
  logic             ifu_ir_rdy;
  logic [31:0]      ifu_pc;
  logic [31:0]      ifu_ir;
  logic             ifu_misalgn;
  logic             ifu_buserr;
  logic             iq_ir_vld;
  logic             iq_ir_rdy;
  logic [31:0]      iq_pc;
  logic [31:0]      iq_ir;
  logic             iq_misalgn;
  logic             iq_buserr;
  logic             iq_ilegl;
  logic [CNT_W-1:0] iq_count;

  lnrv_ifu_iqueue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pipe_flush_req (pipe_flush_req),
    .ifu_ir_vld     (ifu_ir_vld),
    .ifu_ir_rdy     (ifu_ir_rdy),
    .ifu_pc         (ifu_pc),
    .ifu_ir         (ifu_ir),
    .ifu_misalgn    (ifu_misalgn),
    .ifu_buserr     (ifu_buserr),
    .iq_ir_vld      (iq_ir_vld),
    .iq_ir_rdy      (iq_ir_rdy),
    .iq_pc          (iq_pc),
    .iq_ir          (iq_ir),
    .iq_misalgn     (iq_misalgn),
    .iq_buserr      (iq_buserr),
    .iq_ilegl       (iq_ilegl),
    .iq_count       (iq_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst_n, flush, vld;
    logic [31:0] pc, ir;
    logic        mis, be, rdy;
    logic        e_vld, e_rdy;
    int          e_cnt;
    logic        chk_pl;
    logic [31:0] e_pc, e_ir;
    logic        e_mis, e_be, e_il;
  } vec_t;

  function automatic vec_t mk(
      input logic rst_n, input logic flush, input logic vld, input logic [31:0] pc, input logic [31:0] ir,
      input logic mis, input logic be, input logic rdy, input logic e_vld, input logic e_rdy, input int e_cnt,
      input logic chk_pl, input logic [31:0] e_pc, input logic [31:0] e_ir, input logic e_mis,
      input logic e_be, input logic e_il);
    vec_t v;
    v.rst_n = rst_n; v.flush = flush; v.vld = vld; v.pc = pc; v.ir = ir;
    v.mis = mis; v.be = be; v.rdy = rdy; v.e_vld = e_vld; v.e_rdy = e_rdy; v.e_cnt = e_cnt;
    v.chk_pl = chk_pl; v.e_pc = e_pc; v.e_ir = e_ir; v.e_mis = e_mis; v.e_be = e_be; v.e_il = e_il;
    return v;
  endfunction

  task automatic drive(input logic rst_n, input logic flush, input logic vld, input logic [31:0] pc,
                       input logic [31:0] ir, input logic mis, input logic be, input logic rdy);
    reset_n = rst_n; pipe_flush_req = flush; ifu_ir_vld = vld; ifu_pc = pc;
    ifu_ir = ir; ifu_misalgn = mis; ifu_buserr = be; iq_ir_rdy = rdy;
  endtask

  vec_t      tbl [28];
  iq_entry_t mq [$];
  iq_entry_t pend;
  logic      pend_vld, held, r_rst, r_flush, r_rdy, e_vld, e_rdy, e_il;

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    //       rst flu vld pc        ir         mi be rdy  evld erdy cnt chk epc       eir        emi ebe eil
    tbl[0]  = mk(1, 0, 0, 32'h0,   32'h0,  0, 0, 0,  0, 1, 0,  1, 32'h0,   32'h0,  0, 0, 0);
    tbl[1]  = mk(1, 0, 1, 32'h100, 32'h13, 0, 0, 0,  0, 1, 0,  1, 32'h0,   32'h0,  0, 0, 0);
    tbl[2]  = mk(1, 0, 1, 32'h104, 32'h13, 0, 0, 0,  1, 1, 1,  1, 32'h100, 32'h13, 0, 0, 0);
    tbl[3]  = mk(1, 0, 1, 32'h108, 32'h13, 0, 0, 0,  1, 1, 2,  1, 32'h100, 32'h13, 0, 0, 0);
    tbl[4]  = mk(1, 0, 1, 32'h10C, 32'h13, 0, 0, 0,  1, 1, 3,  1, 32'h100, 32'h13, 0, 0, 0);
    tbl[5]  = mk(1, 0, 1, 32'h110, 32'h13, 0, 0, 0,  1, 0, 4,  1, 32'h100, 32'h13, 0, 0, 0);
    tbl[6]  = mk(1, 0, 1, 32'h110, 32'h13, 0, 0, 1,  1, 0, 4,  1, 32'h100, 32'h13, 0, 0, 0);
    tbl[7]  = mk(1, 0, 1, 32'h110, 32'h13, 0, 0, 0,  1, 1, 3,  1, 32'h104, 32'h13, 0, 0, 0);
    tbl[8]  = mk(1, 0, 0, 32'h0,   32'h0,  0, 0, 1,  1, 0, 4,  1, 32'h104, 32'h13, 0, 0, 0);
    tbl[9]  = mk(1, 0, 0, 32'h0,   32'h0,  0, 0, 1,  1, 1, 3,  1, 32'h108, 32'h13, 0, 0, 0);
    tbl[10] = mk(1, 0, 0, 32'h0,   32'h0,  0, 0, 1,  1, 1, 2,  1, 32'h10C, 32'h13, 0, 0, 0);
    tbl[11] = mk(1, 0, 0, 32'h0,   32'h0,  0, 0, 1,  1, 1, 1,  1, 32'h110, 32'h13, 0, 0, 0);
    tbl[12] = mk(1, 0, 0, 32'h0,   32'h0,  0, 0, 0,  0, 1, 0,  0, 32'h0,   32'h0,  0, 0, 0);
    tbl[13] = mk(1, 0, 1, 32'h200, 32'h13, 0, 0, 0,  0, 1, 0,  0, 32'h0,   32'h0,  0, 0, 0);
    tbl[14] = mk(1, 0, 1, 32'h204, 32'h13, 0, 0, 0,  1, 1, 1,  1, 32'h200, 32'h13, 0, 0, 0);
    tbl[15] = mk(1, 0, 1, 32'h208, 32'h13, 0, 0, 0,  1, 1, 2,  1, 32'h200, 32'h13, 0, 0, 0);
    tbl[16] = mk(1, 1, 1, 32'h300, 32'h13, 0, 0, 1,  0, 1, 3,  0, 32'h0,   32'h0,  0, 0, 0);
    tbl[17] = mk(1, 0, 0, 32'h0,   32'h0,  0, 0, 1,  0, 1, 0,  0, 32'h0,   32'h0,  0, 0, 0);
    tbl[18] = mk(1, 0, 1, 32'h400, 32'h13, 0, 0, 0,  0, 1, 0,  0, 32'h0,   32'h0,  0, 0, 0);
    tbl[19] = mk(1, 0, 0, 32'h0,   32'h0,  0, 0, 1,  1, 1, 1,  1, 32'h400, 32'h13, 0, 0, 0);
    tbl[20] = mk(1, 0, 1, 32'h500, 32'h1,  0, 0, 0,  0, 1, 0,  0, 32'h0,   32'h0,  0, 0, 0);
    tbl[21] = mk(1, 0, 1, 32'h504, 32'h1,  0, 1, 1,  1, 1, 1,  1, 32'h500, 32'h1,  0, 0, 1);
    tbl[22] = mk(1, 0, 0, 32'h0,   32'h0,  0, 0, 1,  1, 1, 1,  1, 32'h504, 32'h1,  0, 1, 0);
    tbl[23] = mk(1, 0, 1, 32'h508, 32'h2,  1, 0, 0,  0, 1, 0,  0, 32'h0,   32'h0,  0, 0, 0);
    tbl[24] = mk(1, 0, 0, 32'h0,   32'h0,  0, 0, 0,  1, 1, 1,  1, 32'h508, 32'h2,  1, 0, 0);
    tbl[25] = mk(1, 0, 1, 32'h600, 32'h13, 0, 0, 0,  1, 1, 1,  1, 32'h508, 32'h2,  1, 0, 0);
    tbl[26] = mk(0, 0, 0, 32'h0,   32'h0,  0, 0, 0,  1, 1, 2,  1, 32'h508, 32'h2,  1, 0, 0);
    tbl[27] = mk(1, 0, 0, 32'h0,   32'h0,  0, 0, 0,  0, 1, 0,  1, 32'h0,   32'h0,  0, 0, 0);

    @(posedge clk);
    @(posedge clk);

    for (int i = 0; i < 28; i++) begin
      @(posedge clk); #1;
      drive(tbl[i].rst_n, tbl[i].flush, tbl[i].vld, tbl[i].pc, tbl[i].ir, tbl[i].mis, tbl[i].be, tbl[i].rdy);
      @(negedge clk);
      chk($sformatf("t%0d_iq_ir_vld", i), 32'(iq_ir_vld), 32'(tbl[i].e_vld));
      chk($sformatf("t%0d_ifu_ir_rdy", i), 32'(ifu_ir_rdy), 32'(tbl[i].e_rdy));
      chk($sformatf("t%0d_iq_count", i), 32'(iq_count), 32'(tbl[i].e_cnt));
      if (tbl[i].chk_pl) begin
        chk($sformatf("t%0d_iq_pc", i), iq_pc, tbl[i].e_pc);
        chk($sformatf("t%0d_iq_ir", i), iq_ir, tbl[i].e_ir);
        chk($sformatf("t%0d_iq_misalgn", i), 32'(iq_misalgn), 32'(tbl[i].e_mis));
        chk($sformatf("t%0d_iq_buserr", i), 32'(iq_buserr), 32'(tbl[i].e_be));
        chk($sformatf("t%0d_iq_ilegl", i), 32'(iq_ilegl), 32'(tbl[i].e_il));
      end
    end

    // Streaming: one push and one pop per cycle, output one cycle behind input.
    for (int k = 0; k < 17; k++) begin
      @(posedge clk); #1;
      drive(1'b1, 1'b0, (k < 16), 32'h200 + 32'(4 * k), 32'h13, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      chk($sformatf("s%0d_iq_ir_vld", k), 32'(iq_ir_vld), (k == 0) ? 32'd0 : 32'd1);
      chk($sformatf("s%0d_iq_count", k), 32'(iq_count), (k == 0) ? 32'd0 : 32'd1);
      if (k > 0) chk($sformatf("s%0d_iq_pc", k), iq_pc, 32'h200 + 32'(4 * (k - 1)));
    end

    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    mq.delete();
    pend_vld = 1'b0;
    pend     = '0;
    held     = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      r_rst   = ($urandom_range(0, 99) != 0);
      r_flush = ($urandom_range(0, 24) == 0);
      r_rdy   = ($urandom_range(0, 2) != 0);
      if (!held) begin
        pend_vld     = ($urandom_range(0, 3) != 0);
        pend.pc      = $urandom & 32'hFFFF_FFFC;
        pend.ir      = $urandom;
        pend.misalgn = ($urandom_range(0, 7) == 0);
        pend.buserr  = ($urandom_range(0, 7) == 0);
      end
      drive(r_rst, r_flush, pend_vld, pend.pc, pend.ir, pend.misalgn, pend.buserr, r_rdy);
      @(negedge clk);
      e_vld = (mq.size() != 0) && !r_flush;
      e_rdy = (mq.size() < DEPTH) || r_flush;
      chk("rnd_iq_ir_vld", 32'(iq_ir_vld), 32'(e_vld));
      chk("rnd_ifu_ir_rdy", 32'(ifu_ir_rdy), 32'(e_rdy));
      chk("rnd_iq_count", 32'(iq_count), 32'(mq.size()));
      if (e_vld) begin
        e_il = !mq[0].misalgn && !mq[0].buserr && (mq[0].ir[1:0] != 2'b11);
        chk("rnd_iq_pc", iq_pc, mq[0].pc);
        chk("rnd_iq_ir", iq_ir, mq[0].ir);
        chk("rnd_iq_misalgn", 32'(iq_misalgn), 32'(mq[0].misalgn));
        chk("rnd_iq_buserr", 32'(iq_buserr), 32'(mq[0].buserr));
        chk("rnd_iq_ilegl", 32'(iq_ilegl), 32'(e_il));
      end
      if (!r_rst || r_flush) begin
        mq.delete();
      end else begin
        if (e_vld && r_rdy) void'(mq.pop_front());
        if (pend_vld && e_rdy) mq.push_back(pend);
      end
      held = pend_vld && !e_rdy;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lnrv_ifu_iqueue.md
# lnrv_ifu_iqueue

Instruction queue between the fetch unit and the execution unit. It accepts fetched instructions, each with its PC and fetch-exception flags, over the fetch valid/ready handshake and buffers up to DEPTH of them in order. It presents them to the EXU over a second valid/ready handshake and pre-decodes an illegal-length flag. It decouples fetch bus latency from EXU stalls and discards all buffered instructions on a pipeline flush.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- CNT_W, $clog2(DEPTH+1): width of the occupancy count.
- clk  in  1  clock. One clock domain; every register updates on the rising edge.
- reset_n  in  1  reset. Synchronous and active-low.
- pipe_flush_req  in  1  flush. Level, one or more cycles; discards all entries.
- ifu_ir_vld  in  1  fetched instruction valid.
- ifu_ir_rdy  out  1  queue can accept an instruction.
- ifu_pc  in  32  PC of the fetched instruction.
- ifu_ir  in  32  instruction word.
- ifu_misalgn  in  1  fetch address misaligned.
- ifu_buserr  in  1  fetch bus error.
- iq_ir_vld  out  1  head entry valid.
- iq_ir_rdy  in  1  EXU accepts the head entry.
- iq_pc  out  32  head entry PC.
- iq_ir  out  32  head entry instruction.
- iq_misalgn  out  1  head entry misaligned flag.
- iq_buserr  out  1  head entry bus-error flag.
- iq_ilegl  out  1  head entry has ir[1:0] != 2'b11 and no fetch exception. There is no compressed-instruction support.
- iq_count  out  CNT_W  number of valid entries.

## Operation
- Storage: DEPTH entries of {pc, ir, misalgn, buserr}, 66 bits each.
- Pointers: wr_ptr and rd_ptr, each log2(DEPTH)+1 bits. The extra MSB is the wrap bit.
- Empty: the two pointers are equal.
- Full: the low bits are equal and the MSBs differ.
- Push = ifu_ir_vld & ifu_ir_rdy & ~pipe_flush_req. Writes the entry at wr_ptr and increments wr_ptr.
- Pop = iq_ir_vld & iq_ir_rdy. Increments rd_ptr.
- Pointers wrap modulo 2·DEPTH. Slot index is the pointer's low bits.
- ifu_ir_rdy = ~full | pipe_flush_req.
  - There is no combinational path from iq_ir_rdy to ifu_ir_rdy.
  - While flushing, the IFU's in-flight instruction is accepted and dropped.
- iq_ir_vld = ~empty & ~pipe_flush_req.
- iq_pc, iq_ir, iq_misalgn and iq_buserr are the head slot read combinationally.
  - They hold the last head contents when iq_ir_vld = 0.
- iq_ilegl = iq_ir_vld & ~iq_misalgn & ~iq_buserr & (iq_ir[1:0] != 2'b11).
- Flush: on any edge with pipe_flush_req = 1, wr_ptr and rd_ptr are cleared to 0.
  - Flush overrides a simultaneous push and pop.
- Push and pop in the same cycle: both happen and the count is unchanged.
  - This is legal when full (the pop frees a slot). ifu_ir_rdy is still 0 in that cycle, so no push actually occurs.
- Push and pop on an empty queue: only the push happens. There is no bypass.
- Protocol checks (simulation only):
  - The producer must hold ifu_pc, ifu_ir and the flags stable while ifu_ir_vld=1 & ifu_ir_rdy=0.
  - iq_* outputs are stable while iq_ir_vld=1 & iq_ir_rdy=0.

## Timing
- Reset (reset_n=0 at an edge):
  - wr_ptr=0, rd_ptr=0, all storage cleared to 0.
  - Outputs: iq_ir_vld=0, ifu_ir_rdy=1, iq_count=0, iq_pc=0, iq_ir=0, iq_misalgn=0, iq_buserr=0, iq_ilegl=0.
- Reset asserted mid-operation discards all contents at that edge, exactly like a flush.
- Latency: an entry pushed at edge N is visible on iq_* with iq_ir_vld=1 in cycle N+1.
- Throughput: one push and one pop per cycle in steady state.
- iq_count is registered and reflects edge results.
  - It rises by 1 on push only, falls by 1 on pop only, and becomes 0 on flush.
- ifu_ir_rdy drops in the cycle after the push that fills the queue. It returns in the cycle after the first pop from full.
- iq_ir_vld is 0 in every cycle where pipe_flush_req=1 and in the cycle after the flush edge, unless a new push occurred in that cycle.

## Structure
- Constants LNRV_IQ_DEPTH (default depth) and LNRV_XLEN (32) go in lnrv_def.v.
- Sub-module lnrv_gnrl_sync_fifo: generic synchronous FIFO with parameters DW and DEPTH. It provides the pointer, storage and full/empty logic plus a clear input.
- lnrv_ifu_iqueue wraps it and adds the payload pack/unpack, flush gating, ilegl pre-decode and count.
- Instantiated between lnrv_ifu and the EXU.

## Test plan
- Fill: DEPTH=4, iq_ir_rdy=0, push pc 0x100, 0x104, 0x108, 0x10C.
  - Expect iq_count=4 and ifu_ir_rdy=0 after the 4th edge.
  - The head holds pc=0x100 throughout.
- Streaming: iq_ir_rdy=1, continuous pushes of pc 0x200..0x23C.
  - Expect in-order output one cycle behind input, iq_count steady at 1, and no bubbles.
- Full with simultaneous pop:
  - With the queue full and ifu_ir_vld=1, assert iq_ir_rdy for 1 cycle.
  - Expect count 3, then a push next cycle back to 4.
  - Order preserved across the wrap of wr_ptr.
- Flush: 3 entries queued, pipe_flush_req=1 for 1 cycle with ifu_ir_vld=1, pc 0x300.
  - Expect iq_ir_vld=0 in that cycle and the next.
  - Expect iq_count=0, with 0x300 dropped.
  - A subsequent push of 0x400 appears next.
- Exceptions and pre-decode:
  - Push ir=0x00000013 → iq_ilegl=0.
  - Push ir=0x00000001 → iq_ilegl=1.
  - Push with buserr=1 and ir=0x1 → iq_buserr=1, iq_ilegl=0.
- Reset mid-stream: reset_n=0 for 1 edge with 2 entries queued.
  - Expect all outputs at their reset values and ifu_ir_rdy=1.
